// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32 subset core: PC, fetch/data handshakes, strobe gating.
// Optional performance counters (cycle_cnt, instret_cnt) are built when CORE_SEQ_PERF_EN is defined.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  output logic [31:0] pc,
  input  logic        dec_rf_we,
  input  logic        dec_mem_we,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        dec_jump_reg,
  input  logic        br_ne,
  input  logic [11:0] imm12,
  input  logic [31:0] rs1_data,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        wb_link,
  output logic        halted
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        imem_pend;
  logic        taken;
  logic [31:0] next_pc;
  logic [31:0] next_pc_calc;

  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    return $signed({{20{v[11]}}, v});
  endfunction

  function automatic logic signed [31:0] sext13(input logic [12:0] v);
    return $signed({{19{v[12]}}, v});
  endfunction

  // Target selection: jump beats jump_reg beats branch; all sums wrap modulo 2^32.
  always_comb begin
    taken        = dec_branch & (alu_zero ^ br_ne);
    next_pc_calc = pc + 32'd4;
    if (dec_jump) begin
      next_pc_calc = pc + $unsigned(sext13({imm12, 1'b0}));
    end else if (dec_jump_reg) begin
      next_pc_calc = (rs1_data + $unsigned(sext12(imm12))) & ~32'h1;
    end else if (taken) begin
      next_pc_calc = pc + $unsigned(sext12(imm12));
    end
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_link  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        // halt_req is only honoured before a request goes out; an open fetch always completes.
        if (!imem_pend && halt_req) begin
          state_nx = S_HALT;
        end else if (rst_n) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we    = 1'b1;
            state_nx = S_DECODE;
          end
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = dec_mem_we ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ack) begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        rf_we    = dec_rf_we & ~dec_mem_we;
        wb_link  = dec_jump | dec_jump_reg;
        state_nx = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      imem_pend <= 1'b0;
      pc        <= RESET_PC;
    end else begin
      state     <= state_nx;
      imem_pend <= imem_req & ~imem_ack;
      if (state == S_WB) begin
        pc <= next_pc;
      end
    end
  end

  // EXEC -> WB boundary: target held until the write-back cycle commits it to pc.
  always_ff @(posedge clk) begin
    if (state == S_EXEC) begin
      next_pc <= next_pc_calc;
    end
  end

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_WB) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end
`endif

  strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({rf_we, ir_we, dmem_we}));

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle comparison against an instruction-level model.
module tb_core_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt_req;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic [31:0] pc;
  logic        dec_rf_we, dec_mem_we, dec_branch, dec_jump, dec_jump_reg, br_ne;
  logic [11:0] imm12;
  logic [31:0] rs1_data;
  logic        alu_zero;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, wb_link, halted;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  core_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we), .pc(pc),
    .dec_rf_we(dec_rf_we), .dec_mem_we(dec_mem_we), .dec_branch(dec_branch),
    .dec_jump(dec_jump), .dec_jump_reg(dec_jump_reg), .br_ne(br_ne),
    .imm12(imm12), .rs1_data(rs1_data), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_link(wb_link), .halted(halted)
`ifdef CORE_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic        e_imem_req, e_ir_we, e_dmem_req, e_dmem_we, e_rf_we, e_wb_link, e_halted;
  logic [31:0] e_pc;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cyc <= 32'd0;
    else        m_cyc <= m_cyc + 32'd1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, e_imem_req});
      chk("ir_we",    {31'd0, ir_we},    {31'd0, e_ir_we});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_dmem_req});
      chk("dmem_we",  {31'd0, dmem_we},  {31'd0, e_dmem_we});
      chk("rf_we",    {31'd0, rf_we},    {31'd0, e_rf_we});
      chk("wb_link",  {31'd0, wb_link},  {31'd0, e_wb_link});
      chk("halted",   {31'd0, halted},   {31'd0, e_halted});
      chk("pc",       pc,                e_pc);
`ifdef CORE_SEQ_PERF_EN
      chk("cycle_cnt",   cycle_cnt,   m_cyc);
      chk("instret_cnt", instret_cnt, m_inst);
`endif
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp;
    e_imem_req = 1'b0; e_ir_we = 1'b0; e_dmem_req = 1'b0; e_dmem_we = 1'b0;
    e_rf_we = 1'b0; e_wb_link = 1'b0; e_halted = 1'b0; e_pc = m_pc;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic br, j, jr, ne, az,
                                             input logic [11:0] imm, input logic [31:0] rs1);
    logic signed [31:0] off;
    off = $signed(imm);
    if (j)  return cur + off * 2;
    if (jr) return (rs1 + off) & 32'hFFFF_FFFE;
    if (br && (ne ? !az : az)) return cur + off;
    return cur + 32'd4;
  endfunction

  // iw/dw: request cycles including the ack cycle; rst_at: MEM cycle on which reset hits (0 = none).
  task automatic run_instr(input logic rf, st, br, j, jr, ne, input logic [11:0] imm,
                           input logic [31:0] rs1, input logic az, input int iw, input int dw,
                           input int rst_at, input logic halt_mid);
    logic [31:0] nxt;
    chk_en = 1'b1;
    dec_rf_we = rf; dec_mem_we = st; dec_branch = br; dec_jump = j; dec_jump_reg = jr;
    br_ne = ne; imm12 = imm; rs1_data = rs1; alu_zero = az;
    nxt = model_next(m_pc, br, j, jr, ne, az, imm, rs1);
    for (int k = 1; k <= iw; k++) begin
      clear_exp;
      e_imem_req = 1'b1;
      e_ir_we    = (k == iw);
      imem_ack   = (k == iw);
      dmem_ack   = 1'b1;
      halt_req   = halt_mid && (k >= 2);
      step;
    end
    for (int k = 0; k < 2; k++) begin
      clear_exp;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      step;
    end
    if (st) begin
      for (int k = 1; k <= dw; k++) begin
        clear_exp;
        e_dmem_req = 1'b1;
        e_dmem_we  = 1'b1;
        dmem_ack   = (k == dw);
        imem_ack   = 1'b1;
        if (k == rst_at) begin
          #3;
          chk_en = 1'b0;
          rst_n  = 1'b0;
          #1;
          chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
          chk("rst_dmem_we",  {31'd0, dmem_we},  32'd0);
          chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
          chk("rst_pc",       pc,                RPC);
          step;
          step;
          rst_n  = 1'b1;
          m_pc   = RPC;
          m_inst = 32'd0;
          return;
        end
        step;
      end
    end
    clear_exp;
    e_rf_we   = rf & ~st;
    e_wb_link = j | jr;
    imem_ack  = 1'b1;
    dmem_ack  = 1'b1;
    step;
    m_pc   = nxt;
    m_inst = m_inst + 32'd1;
  endtask

  initial begin
    rst_n = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_rf_we = 1'b0; dec_mem_we = 1'b0; dec_branch = 1'b0; dec_jump = 1'b0;
    dec_jump_reg = 1'b0; br_ne = 1'b0; imm12 = 12'h0; rs1_data = 32'h0; alu_zero = 1'b0;
    m_pc = RPC; m_inst = 32'd0;
    clear_exp;
    step;
    step;
    chk("reset_pc",       pc,                RPC);
    chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
    chk("reset_ir_we",    {31'd0, ir_we},    32'd0);
    chk("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset_rf_we",    {31'd0, rf_we},    32'd0);
    chk("reset_wb_link",  {31'd0, wb_link},  32'd0);
    chk("reset_halted",   {31'd0, halted},   32'd0);
    rst_n = 1'b1;

    //        rf  st  br  j   jr  ne  imm      rs1           az  iw dw rst halt
    run_instr(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,        0, 1, 0, 0, 0);  // ADDI
    chk("pc_addi", pc, 32'h0000_0104);
    run_instr(1, 0, 0, 0, 1, 0, 12'h001, 32'h0000_01FF, 0, 1, 0, 0, 0); // JALR to 0x200
    chk("pc_jalr_lsb", pc, 32'h0000_0200);
    run_instr(0, 0, 1, 0, 0, 0, 12'h010, 32'h0,        1, 1, 0, 0, 0);  // BEQ taken
    chk("pc_beq_taken", pc, 32'h0000_0210);
    run_instr(1, 0, 0, 0, 1, 0, 12'h000, 32'h0000_0200, 0, 1, 0, 0, 0);
    run_instr(0, 0, 1, 0, 0, 0, 12'h010, 32'h0,        0, 1, 0, 0, 0);  // BEQ not taken
    chk("pc_beq_not", pc, 32'h0000_0204);
    run_instr(1, 0, 0, 0, 1, 0, 12'h000, 32'h0000_0200, 0, 1, 0, 0, 0);
    run_instr(0, 0, 1, 0, 0, 1, 12'h010, 32'h0,        0, 1, 0, 0, 0);  // BNE taken
    chk("pc_bne_taken", pc, 32'h0000_0210);
    run_instr(0, 0, 1, 0, 0, 0, 12'hFF0, 32'h0,        1, 1, 0, 0, 0);  // BEQ backwards
    chk("pc_beq_back", pc, 32'h0000_0200);
    run_instr(1, 0, 0, 0, 1, 0, 12'h002, 32'h0000_1235, 0, 2, 0, 0, 0); // JALR
    chk("pc_jalr", pc, 32'h0000_1236);
    run_instr(1, 0, 0, 0, 1, 0, 12'h000, 32'hFFFF_FFF0, 0, 1, 0, 0, 0);
    run_instr(1, 0, 0, 1, 0, 0, 12'h010, 32'h0,        0, 1, 0, 0, 0);  // JAL wrap
    chk("pc_jal_wrap", pc, 32'h0000_0010);
    run_instr(1, 0, 1, 1, 0, 0, 12'h004, 32'h0,        1, 1, 0, 0, 0);  // jump beats branch
    chk("pc_prio_jal", pc, 32'h0000_0018);
    run_instr(1, 0, 1, 0, 1, 0, 12'h004, 32'h0000_0040, 1, 1, 0, 0, 0); // jump_reg beats branch
    chk("pc_prio_jalr", pc, 32'h0000_0044);
    run_instr(0, 0, 0, 0, 0, 0, 12'h7FF, 32'h0,        1, 1, 0, 0, 0);  // unknown opcode
    chk("pc_nop", pc, 32'h0000_0048);
    run_instr(1, 1, 0, 0, 0, 0, 12'h000, 32'h0,        0, 1, 3, 0, 0);  // SW, ack on 3rd cycle
    chk("pc_sw_slow", pc, 32'h0000_004C);
    run_instr(0, 1, 0, 0, 0, 0, 12'h000, 32'h0,        0, 3, 1, 0, 0);  // SW, same-cycle ack
    chk("pc_sw_fast", pc, 32'h0000_0050);
    run_instr(0, 1, 0, 0, 0, 0, 12'h000, 32'h0,        0, 1, 4, 2, 0);  // reset during MEM
    run_instr(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,        0, 3, 0, 0, 1);  // halt_req mid-fetch
    chk("pc_after_rst", pc, 32'h0000_0104);

    for (int n = 0; n < 6; n++) begin
      clear_exp;
      e_halted = (n > 0);
      imem_ack = 1'b1;
      step;
    end
    chk("halt_pc_frozen", pc, 32'h0000_0104);
    chk("halt_flag", {31'd0, halted}, 32'd1);
`ifdef CORE_SEQ_PERF_EN
    chk("halt_instret", instret_cnt, 32'd1);
`endif
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
